// File: rtl/vend_disp_sched.sv
// vend_disp_sched
// Display scheduler for the vending machine's 6-digit seven-segment driver.
// Chooses between the idle display (inserted amount, or price when nothing is
// inserted), a timed change-return display and a blinking insufficient-funds
// alert. It produces the binary value and the active-low decimal-point mask
// for the segment driver. A change request that arrives during an alert is
// deferred and shown once the alert ends.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   amt_val    inserted amount (units of 0.01)
//   price_val  selected item price (units of 0.01)
//   chg_req    one-cycle pulse: show chg_val as change
//   chg_val    change amount, sampled with chg_req
//   err_req    one-cycle pulse: start the insufficient-funds alert
//   clr        abort all timed displays and drop any pending request
//   seg_value  value to the segment driver (bits 24:20 always 0)
//   dot        active-low DP mask, dot[5] rightmost digit, dot[0] leftmost
//   disp_mode  0=IDLE, 1=CHG, 2=ERR
//   busy       a timed display is active or a change request is pending
// All outputs are registered and reflect the previous cycle's state and inputs.
module vend_disp_sched #(
  parameter int HOLD_CNT    = 150_000_000,
  parameter int BLINK_CNT   = 25_000_000,
  parameter int ERR_TOGGLES = 6,
  parameter int MAX_VAL     = 999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] amt_val,
  input  logic [19:0] price_val,
  input  logic        chg_req,
  input  logic [19:0] chg_val,
  input  logic        err_req,
  input  logic        clr,
  output logic [24:0] seg_value,
  output logic [5:0]  dot,
  output logic [1:0]  disp_mode,
  output logic        busy
);

  localparam int HW = $clog2(HOLD_CNT + 1);
  localparam int BW = $clog2(BLINK_CNT + 1);
  localparam int TW = $clog2(ERR_TOGGLES + 1);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CNT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);
  localparam logic [TW-1:0] TOG_LAST   = TW'(ERR_TOGGLES - 1);
  localparam logic [19:0]   MAX_V      = 20'(MAX_VAL);

  localparam logic [5:0] DOT_OFF  = 6'b111111;
  localparam logic [5:0] DOT_NORM = 6'b110111;  // DP on the hundreds digit: X.XX
  localparam logic [5:0] DOT_ALL  = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CHG  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t          state_r;
  logic [HW-1:0]   hold_cnt_r;
  logic [BW-1:0]   blink_cnt_r;
  logic [TW-1:0]   tog_cnt_r;
  logic            phase_on_r;
  logic            pend_r;
  logic [19:0]     pend_val_r;
  logic [19:0]     chg_val_r;

  // Clamp a value to the displayable range.
  function automatic logic [19:0] sat_val(input logic [19:0] v);
    if (v > MAX_V) begin
      return MAX_V;
    end else begin
      return v;
    end
  endfunction

  // Scheduler FSM: registered outputs from the current state, then next-state update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      hold_cnt_r  <= '0;
      blink_cnt_r <= '0;
      tog_cnt_r   <= '0;
      phase_on_r  <= 1'b1;
      pend_r      <= 1'b0;
      pend_val_r  <= 20'd0;
      chg_val_r   <= 20'd0;
      seg_value   <= 25'd0;
      dot         <= DOT_OFF;
      disp_mode   <= 2'd0;
      busy        <= 1'b0;
    end else begin
      // Output stage: what the current state shows this cycle.
      busy <= (state_r != ST_IDLE) || pend_r;
      case (state_r)
        ST_IDLE: begin
          seg_value <= {5'd0, sat_val((amt_val != 20'd0) ? amt_val : price_val)};
          dot       <= DOT_NORM;
          disp_mode <= 2'd0;
        end
        ST_CHG: begin
          seg_value <= {5'd0, sat_val(chg_val_r)};
          dot       <= DOT_NORM;
          disp_mode <= 2'd1;
        end
        ST_ERR: begin
          seg_value <= {5'd0, sat_val(price_val)};
          dot       <= phase_on_r ? DOT_ALL : DOT_NORM;
          disp_mode <= 2'd2;
        end
        default: begin
          seg_value <= 25'd0;
          dot       <= DOT_OFF;
          disp_mode <= 2'd0;
        end
      endcase

      // Transition stage: clr beats err_req, which beats chg_req.
      if (clr) begin
        state_r     <= ST_IDLE;
        hold_cnt_r  <= '0;
        blink_cnt_r <= '0;
        tog_cnt_r   <= '0;
        phase_on_r  <= 1'b1;
        pend_r      <= 1'b0;
      end else if (err_req) begin
        // (Re)start the alert; a simultaneous change request is deferred.
        state_r     <= ST_ERR;
        hold_cnt_r  <= '0;
        blink_cnt_r <= '0;
        tog_cnt_r   <= '0;
        phase_on_r  <= 1'b1;
        if (chg_req) begin
          pend_r     <= 1'b1;
          pend_val_r <= chg_val;
        end else if (state_r != ST_ERR) begin
          pend_r <= 1'b0;
        end else begin
          pend_r <= pend_r;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (chg_req) begin
              state_r    <= ST_CHG;
              chg_val_r  <= chg_val;
              hold_cnt_r <= '0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_CHG: begin
            if (chg_req) begin
              chg_val_r  <= chg_val;
              hold_cnt_r <= '0;
            end else if (hold_cnt_r == HOLD_LAST) begin
              state_r    <= ST_IDLE;
              hold_cnt_r <= '0;
            end else begin
              hold_cnt_r <= hold_cnt_r + HW'(1);
            end
          end
          ST_ERR: begin
            if (chg_req) begin
              pend_r     <= 1'b1;
              pend_val_r <= chg_val;
            end else begin
              pend_r <= pend_r;
            end
            if (blink_cnt_r == BLINK_LAST) begin
              blink_cnt_r <= '0;
              phase_on_r  <= ~phase_on_r;
              if (tog_cnt_r == TOG_LAST) begin
                // Alert finished: hand over to a deferred change display if one waits.
                tog_cnt_r  <= '0;
                phase_on_r <= 1'b1;
                hold_cnt_r <= '0;
                if (pend_r || chg_req) begin
                  state_r   <= ST_CHG;
                  chg_val_r <= chg_req ? chg_val : pend_val_r;
                  pend_r    <= 1'b0;
                end else begin
                  state_r <= ST_IDLE;
                end
              end else begin
                tog_cnt_r <= tog_cnt_r + TW'(1);
              end
            end else begin
              blink_cnt_r <= blink_cnt_r + BW'(1);
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vend_disp_sched.sv
// Testbench for vend_disp_sched: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model that tracks the
// display as "remaining change time" and "elapsed alert time".
module tb_vend_disp_sched;

  localparam int HOLD  = 10;
  localparam int BLINK = 4;
  localparam int TOGS  = 6;
  localparam int MAXV  = 999_999;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] amt_val, price_val, chg_val;
  logic        chg_req, err_req, clr;
  logic [24:0] seg_value;
  logic [5:0]  dot;
  logic [1:0]  disp_mode;
  logic        busy;

  always #5 clk = ~clk;

  vend_disp_sched #(
    .HOLD_CNT(HOLD), .BLINK_CNT(BLINK), .ERR_TOGGLES(TOGS), .MAX_VAL(MAXV)
  ) dut (
    .clk(clk), .rst(rst), .amt_val(amt_val), .price_val(price_val),
    .chg_req(chg_req), .chg_val(chg_val), .err_req(err_req), .clr(clr),
    .seg_value(seg_value), .dot(dot), .disp_mode(disp_mode), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
  endtask

  // Behavioural model: mode 0=idle, 1=change, 2=alert.
  int m_mode = 0, m_left = 0, m_elapsed = 0, m_cval = 0, m_pval = 0;
  bit m_pend = 0, m_valid = 0;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // One clock: predict outputs, advance model, clock DUT, compare, drop pulses.
  task automatic step();
    int e_seg, e_dot, e_mode, e_busy;
    bit do_chk;
    do_chk = rst || m_valid;
    if (rst) begin
      e_seg = 0; e_dot = 6'b111111; e_mode = 0; e_busy = 0;
    end else begin
      e_busy = (m_mode != 0 || m_pend) ? 1 : 0;
      e_mode = m_mode;
      e_dot  = 6'b110111;
      if (m_mode == 0) e_seg = sat((amt_val != 0) ? int'(amt_val) : int'(price_val));
      else if (m_mode == 1) e_seg = sat(m_cval);
      else begin
        e_seg = sat(int'(price_val));
        if (((m_elapsed / BLINK) % 2) == 0) e_dot = 6'b000000;
      end
    end
    if (rst) begin
      m_mode = 0; m_pend = 0; m_left = 0; m_elapsed = 0; m_cval = 0; m_pval = 0; m_valid = 1;
    end else if (clr) begin
      m_mode = 0; m_pend = 0;
    end else if (err_req) begin
      if (chg_req) begin m_pend = 1; m_pval = chg_val; end
      else if (m_mode != 2) m_pend = 0;
      m_mode = 2; m_elapsed = 0;
    end else if (m_mode == 0) begin
      if (chg_req) begin m_mode = 1; m_cval = chg_val; m_left = HOLD; end
    end else if (m_mode == 1) begin
      if (chg_req) begin m_cval = chg_val; m_left = HOLD; end
      else begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    end else begin
      if (chg_req) begin m_pend = 1; m_pval = chg_val; end
      m_elapsed++;
      if (m_elapsed == TOGS * BLINK) begin
        if (m_pend) begin m_mode = 1; m_cval = m_pval; m_left = HOLD; m_pend = 0; end
        else m_mode = 0;
      end
    end
    @(posedge clk);
    #1;
    if (do_chk) begin
      check_val("seg_value", 32'(seg_value), e_seg);
      check_val("dot", 32'(dot), e_dot);
      check_val("disp_mode", 32'(disp_mode), e_mode);
      check_val("busy", 32'(busy), e_busy);
    end
    chg_req = 1'b0; err_req = 1'b0; clr = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; amt_val = 20'd0; price_val = 20'd0; chg_val = 20'd0;
    chg_req = 1'b0; err_req = 1'b0; clr = 1'b0;

    // Reset then idle display
    steps(2);
    rst = 1'b0; price_val = 20'd350;
    steps(3);
    // Timed change display
    amt_val = 20'd200;
    steps(2);
    chg_val = 20'd150; chg_req = 1'b1;
    steps(14);
    // Alert blink from idle
    amt_val = 20'd0; err_req = 1'b1;
    steps(28);
    // Deferred change, overwritten mid-alert
    err_req = 1'b1;
    steps(8);
    chg_val = 20'd50; chg_req = 1'b1;
    steps(3);
    chg_val = 20'd70; chg_req = 1'b1;
    steps(30);
    // Same-cycle priority
    err_req = 1'b1; chg_req = 1'b1; chg_val = 20'd90; clr = 1'b1;
    steps(4);
    err_req = 1'b1; chg_req = 1'b1; chg_val = 20'd80;
    steps(40);
    // Saturation
    amt_val = 20'd1_048_575;
    steps(2);
    check_val("sat_idle", 32'(seg_value), 32'd999_999);
    // Reset mid-change
    chg_val = 20'd123; chg_req = 1'b1;
    steps(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(15);
    // Reset mid-alert with a pending change
    err_req = 1'b1;
    steps(3);
    chg_req = 1'b1; chg_val = 20'd44;
    steps(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(30);

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      amt_val   = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom);
      price_val = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'($urandom_range(0, 2000));
      chg_val   = ($urandom_range(0, 7) == 0) ? 20'($urandom) : 20'($urandom_range(0, 1000));
      chg_req   = ($urandom_range(0, 15) == 0);
      err_req   = ($urandom_range(0, 39) == 0);
      clr       = ($urandom_range(0, 99) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
